// File: rtl/cfg_pkg.sv
// Shared types and default widths for the configuration-chain loader.
package cfg_pkg;

    localparam int CFG_WORD_W = 32;
    localparam int CFG_LEN_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_SHIFT  = 2'd2,
        ST_FINISH = 2'd3
    } cfg_state_e;

endpackage

// File: rtl/cfg_deser.sv
// Readback capture: packs cfg_sin samples into words, emitting a short final word zero-padded.
module cfg_deser
    import cfg_pkg::*;
#(
    parameter int WORD_W = CFG_WORD_W,
    parameter int LEN_W  = CFG_LEN_W
) (
    input  logic              config_clk,
    input  logic              config_reset,
    input  logic              sample,
    input  logic              last,
    input  logic              sin,
    output logic              rb_valid,
    output logic [WORD_W-1:0] rb_data
);

    logic [LEN_W-1:0]  rb_cnt_q, rb_cnt_d;
    logic [WORD_W-1:0] rb_shreg_q, rb_shreg_d;
    logic              rb_valid_q, rb_valid_d;
    logic [WORD_W-1:0] rb_data_q, rb_data_d;
    logic [WORD_W-1:0] word_w;
    logic              word_end;

    always_ff @(posedge config_clk or negedge config_reset) begin
        if (!config_reset) begin
            rb_cnt_q   <= '0;
            rb_shreg_q <= '0;
            rb_valid_q <= 1'b0;
            rb_data_q  <= '0;
        end else begin
            rb_cnt_q   <= rb_cnt_d;
            rb_shreg_q <= rb_shreg_d;
            rb_valid_q <= rb_valid_d;
            rb_data_q  <= rb_data_d;
        end
    end

    always_comb begin
        word_w     = rb_shreg_q | (WORD_W'(sin) << rb_cnt_q);
        word_end   = (rb_cnt_q == LEN_W'(WORD_W - 1)) || last;
        rb_cnt_d   = rb_cnt_q;
        rb_shreg_d = rb_shreg_q;
        rb_valid_d = 1'b0;
        rb_data_d  = rb_data_q;
        if (sample) begin
            if (word_end) begin
                rb_valid_d = 1'b1;
                rb_data_d  = word_w;
                rb_shreg_d = '0;
                rb_cnt_d   = '0;
            end else begin
                rb_shreg_d = word_w;
                rb_cnt_d   = rb_cnt_q + LEN_W'(1);
            end
        end
    end

    assign rb_valid = rb_valid_q;
    assign rb_data  = rb_data_q;

endmodule

// File: rtl/config_loader.sv
// Streams a bitstream into a config_cell chain LSB-first and captures the old contents as readback.
//   state  | meaning
//   IDLE   | waiting for start
//   FETCH  | word_ready high, chain held until a word arrives
//   SHIFT  | one chain shift per cycle from shreg
//   FINISH | one-cycle done pulse
module config_loader
    import cfg_pkg::*;
#(
    parameter int WORD_W = CFG_WORD_W,
    parameter int LEN_W  = CFG_LEN_W
) (
    input  logic              config_clk,
    input  logic              config_reset,
    input  logic              start,
    input  logic [LEN_W-1:0]  chain_len,
    input  logic              word_valid,
    input  logic [WORD_W-1:0] word_data,
    output logic              word_ready,
    output logic              cfg_sout,
    input  logic              cfg_sin,
    output logic              cfg_shift_en,
    output logic              busy,
    output logic              done,
    output logic              rb_valid,
    output logic [WORD_W-1:0] rb_data
);

    cfg_state_e        state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [LEN_W-1:0]  word_bit_q, word_bit_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic              cfg_shift_en_q;
    logic              in_shift, last_bit, word_end, accept;

    always_ff @(posedge config_clk or negedge config_reset) begin
        if (!config_reset) begin
            state_q        <= ST_IDLE;
            len_q          <= '0;
            bit_cnt_q      <= '0;
            word_bit_q     <= '0;
            shreg_q        <= '0;
            cfg_shift_en_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            len_q          <= len_d;
            bit_cnt_q      <= bit_cnt_d;
            word_bit_q     <= word_bit_d;
            shreg_q        <= shreg_d;
            cfg_shift_en_q <= (state_d == ST_SHIFT);
        end
    end

    assign in_shift = (state_q == ST_SHIFT);
    assign last_bit = (bit_cnt_q == len_q - LEN_W'(1));
    assign word_end = (word_bit_q == LEN_W'(WORD_W - 1));
    assign accept   = word_valid && word_ready;

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        bit_cnt_d  = bit_cnt_q;
        word_bit_d = word_bit_q;
        shreg_d    = shreg_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    len_d     = chain_len;
                    bit_cnt_d = '0;
                    state_d   = (chain_len == '0) ? ST_FINISH : ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (accept) begin
                    shreg_d    = word_data;
                    word_bit_d = '0;
                    state_d    = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                shreg_d    = shreg_q >> 1;
                bit_cnt_d  = bit_cnt_q + LEN_W'(1);
                word_bit_d = word_bit_q + LEN_W'(1);
                if (last_bit) begin
                    state_d = ST_FINISH;
                end else if (word_end) begin
                    // A word offered on the last bit of the current one refills with no bubble.
                    if (accept) begin
                        shreg_d    = word_data;
                        word_bit_d = '0;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        word_ready = (state_q == ST_FETCH) || (in_shift && word_end && !last_bit);
        busy       = (state_q != ST_IDLE);
        done       = (state_q == ST_FINISH);
        cfg_sout   = in_shift ? shreg_q[0] : 1'b0;
    end

    assign cfg_shift_en = cfg_shift_en_q;

    cfg_deser #(
        .WORD_W (WORD_W),
        .LEN_W  (LEN_W)
    ) u_deser (
        .config_clk   (config_clk),
        .config_reset (config_reset),
        .sample       (cfg_shift_en_q),
        .last         (in_shift && last_bit),
        .sin          (cfg_sin),
        .rb_valid     (rb_valid),
        .rb_data      (rb_data)
    );

endmodule

// File: tb/tb_config_loader.sv
// Directed bench: loader driving a 12-bit chain of three 4-bit config cells.
module tb_config_loader;

    localparam int WORD_W = 32;
    localparam int LEN_W  = 16;

    logic              config_clk   = 1'b0;
    logic              config_reset = 1'b0;
    logic              start        = 1'b0;
    logic [LEN_W-1:0]  chain_len    = '0;
    logic              word_valid   = 1'b0;
    logic [WORD_W-1:0] word_data    = '0;
    logic              word_ready, cfg_sout, cfg_sin, cfg_shift_en, busy, done, rb_valid;
    logic [WORD_W-1:0] rb_data;

    // chain[11:8] is the first cell, chain[3:0] the last; cfg_sin is the last cell's output.
    logic [11:0] chain = '0;
    assign cfg_sin = chain[0];

    always #5 config_clk = ~config_clk;

    always @(posedge config_clk) if (cfg_shift_en) chain <= {cfg_sout, chain[11:1]};

    config_loader #(.WORD_W(WORD_W), .LEN_W(LEN_W)) dut (
        .config_clk   (config_clk),
        .config_reset (config_reset),
        .start        (start),
        .chain_len    (chain_len),
        .word_valid   (word_valid),
        .word_data    (word_data),
        .word_ready   (word_ready),
        .cfg_sout     (cfg_sout),
        .cfg_sin      (cfg_sin),
        .cfg_shift_en (cfg_shift_en),
        .busy         (busy),
        .done         (done),
        .rb_valid     (rb_valid),
        .rb_data      (rb_data)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    int          r_shift, r_gap, r_ready, r_rb_cnt, r_acc, r_done, r_done_seen;
    logic [31:0] r_rb_first, r_rb_last;

    task automatic run_load(input logic [15:0] len, input logic [31:0] w0, input logic [31:0] w1,
                            input int nwords, input int hold1, input int restart_cyc);
        logic [31:0] words [2];
        int cyc, idx, hold, first_sh, last_sh;
        words[0] = w0;
        words[1] = w1;
        r_shift = 0; r_ready = 0; r_rb_cnt = 0; r_acc = -1; r_done = -1; r_done_seen = 0;
        r_rb_first = '0; r_rb_last = '0;
        idx = 0; hold = hold1; first_sh = -1; last_sh = -1; cyc = 0;
        @(negedge config_clk);
        start = 1'b1; chain_len = len; word_valid = 1'b0;
        while (cyc < 200) begin
            if (cfg_shift_en) begin
                r_shift++;
                if (first_sh < 0) first_sh = cyc;
                last_sh = cyc;
            end
            if (word_ready) r_ready++;
            if (rb_valid) begin
                if (r_rb_cnt == 0) r_rb_first = rb_data;
                r_rb_last = rb_data;
                r_rb_cnt++;
            end
            if (done && r_done < 0) begin
                r_done = cyc;
                r_done_seen = 1;
            end
            if (idx < nwords) begin
                if (idx == 1 && hold > 0) begin
                    word_valid = 1'b0;
                    if (word_ready) hold--;
                end else begin
                    word_valid = 1'b1;
                    word_data  = words[idx];
                    if (word_ready) begin
                        if (r_acc < 0) r_acc = cyc;
                        idx++;
                    end
                end
            end else begin
                word_valid = 1'b0;
                word_data  = '0;
            end
            if (r_done >= 0 && cyc >= r_done + 2) break;
            @(negedge config_clk);
            cyc++;
            start = (cyc == restart_cyc);
            if (cyc == restart_cyc) chain_len = '0;
        end
        start = 1'b0;
        word_valid = 1'b0;
        r_gap = (first_sh < 0) ? 0 : (last_sh - first_sh + 1 - r_shift);
    endtask

    int ns, done_abort;

    initial begin
        repeat (2) @(negedge config_clk);
        check_eq("rst_ctrl", {28'd0, cfg_shift_en, word_ready, busy, done}, 32'd0);
        check_eq("rst_sout_rbv", {30'd0, cfg_sout, rb_valid}, 32'd0);
        check_eq("rst_rb_data", rb_data, 32'd0);
        config_reset = 1'b1;
        @(negedge config_clk);

        run_load(16'd0, 32'd0, 32'd0, 0, 0, -1);
        check_eq("len0_done_cyc", r_done, 32'd1);
        check_eq("len0_shifts", r_shift, 32'd0);
        check_eq("len0_ready", r_ready, 32'd0);

        run_load(16'd12, 32'h0000_0ABC, 32'd0, 1, 0, -1);
        check_eq("l12_done_seen", r_done_seen, 32'd1);
        check_eq("l12_shifts", r_shift, 32'd12);
        check_eq("l12_gap", r_gap, 32'd0);
        check_eq("l12_done_after_acc", r_done - r_acc, 32'd13);
        check_eq("l12_cell_last", {28'd0, chain[3:0]}, 32'hC);
        check_eq("l12_cell_mid", {28'd0, chain[7:4]}, 32'hB);
        check_eq("l12_cell_first", {28'd0, chain[11:8]}, 32'hA);
        check_eq("l12_rb_cnt", r_rb_cnt, 32'd1);

        run_load(16'd40, 32'h9876_5432, 32'hFFFF_FF5A, 2, 0, -1);
        check_eq("l40_shifts", r_shift, 32'd40);
        check_eq("l40_gap", r_gap, 32'd0);
        check_eq("l40_ready", r_ready, 32'd2);
        check_eq("l40_done_after_acc", r_done - r_acc, 32'd41);
        check_eq("l40_chain", {20'd0, chain}, 32'h5A9);
        check_eq("l40_rb_cnt", r_rb_cnt, 32'd2);
        check_eq("l40_rb_first", r_rb_first, 32'h6543_2ABC);
        check_eq("l40_rb_last", r_rb_last, 32'h0000_0087);

        run_load(16'd40, 32'h9876_5432, 32'hFFFF_FF5A, 2, 5, -1);
        check_eq("stall_shifts", r_shift, 32'd40);
        check_eq("stall_gap", r_gap, 32'd5);
        check_eq("stall_done_after_acc", r_done - r_acc, 32'd46);
        check_eq("stall_chain", {20'd0, chain}, 32'h5A9);
        check_eq("stall_rb_first", r_rb_first, 32'h6543_25A9);

        run_load(16'd12, 32'h0000_0FFF, 32'd0, 1, 0, 6);
        check_eq("fff_shifts", r_shift, 32'd12);
        check_eq("fff_done_after_acc", r_done - r_acc, 32'd13);
        check_eq("fff_chain", {20'd0, chain}, 32'hFFF);
        check_eq("fff_rb_last", r_rb_last, 32'h5A9);

        run_load(16'd12, 32'h0000_0000, 32'd0, 1, 0, -1);
        check_eq("zero_rb_cnt", r_rb_cnt, 32'd1);
        check_eq("zero_rb_data", r_rb_last, 32'h0000_0FFF);
        check_eq("zero_chain", {20'd0, chain}, 32'h000);

        // abort after six shifted bits
        @(negedge config_clk);
        start = 1'b1; chain_len = 16'd12; word_valid = 1'b1; word_data = 32'h0000_0FFF;
        ns = 0; done_abort = 0;
        for (int c = 0; c < 40 && ns < 6; c++) begin
            @(negedge config_clk);
            start = 1'b0;
            if (cfg_shift_en) ns++;
            if (done) done_abort = 1;
        end
        check_eq("abort_shift_count", ns, 32'd6);
        @(negedge config_clk);
        config_reset = 1'b0;
        #1;
        check_eq("abort_shift_en", {31'd0, cfg_shift_en}, 32'd0);
        check_eq("abort_busy", {31'd0, busy}, 32'd0);
        check_eq("abort_outputs", {26'd0, cfg_sout, word_ready, done, rb_valid, |rb_data, 1'b0}, 32'd0);
        word_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge config_clk);
            if (done) done_abort = 1;
        end
        config_reset = 1'b1;
        check_eq("abort_no_done", done_abort, 32'd0);
        check_eq("abort_chain", {20'd0, chain}, 32'hFC0);

        run_load(16'd12, 32'h0000_0123, 32'd0, 1, 0, -1);
        check_eq("post_done_seen", r_done_seen, 32'd1);
        check_eq("post_shifts", r_shift, 32'd12);
        check_eq("post_done_after_acc", r_done - r_acc, 32'd13);
        check_eq("post_chain", {20'd0, chain}, 32'h123);
        check_eq("post_rb_last", r_rb_last, 32'hFC0);
        check_eq("post_idle", {30'd0, busy, cfg_shift_en}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/config_loader.md
CONFIG_LOADER -- requirements
Module: config_loader

Interface
REQ-001 SHALL have parameter WORD_W, default 32, the width of one bitstream word.
REQ-002 SHALL have parameter LEN_W, default 16, the width of the chain-length field in bits.
REQ-003 config_clk  input  1  single clock for all state.
REQ-004 config_reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  single-cycle pulse that begins a load; ignored unless the block is IDLE.
REQ-006 chain_len  input  LEN_W  number of bits to shift, sampled on an accepted start; 0 is legal.
REQ-007 word_valid  input  1  word_data is valid.
REQ-008 word_data  input  WORD_W  bitstream word, LSB shifted first.
REQ-009 word_ready  output  1  block accepts a word this cycle.
REQ-010 cfg_sout  output  1  serial data to config_in of the first config_cell in the chain.
REQ-011 cfg_sin  input  1  serial data from config_out of the last config_cell (readback).
REQ-012 cfg_shift_en  output  1  clock-enable for the chain's config_clk gate; each high cycle = one chain shift.
REQ-013 busy  output  1  load in progress.
REQ-014 done  output  1  single-cycle pulse when the last bit has shifted.
REQ-015 rb_valid / rb_data  output  1 / WORD_W  readback word captured from cfg_sin.

Function
REQ-016 FSM SHALL have states IDLE, FETCH, SHIFT and FINISH.
REQ-017 In IDLE with start=1: chain_len SHALL be latched and bit_cnt cleared; next state is FINISH if chain_len=0, else FETCH.
REQ-018 In FETCH, word_ready SHALL be 1; on word_valid&word_ready, word_data SHALL load the shift register, word_bit is cleared, and the next state is SHIFT.
REQ-019 In SHIFT, every cycle SHALL assert cfg_shift_en=1, drive cfg_sout=shreg[0], shift shreg right, and increment bit_cnt and word_bit.
REQ-020 In SHIFT, when bit_cnt+1 = latched len, the next state SHALL be FINISH; else when word_bit = WORD_W-1, the next state is FETCH; else stay in SHIFT.
REQ-021 While in FETCH (word starvation), cfg_shift_en SHALL be 0 so the chain holds; a starvation gap has no length limit.
REQ-022 Zero-bubble refill: in the last SHIFT cycle of a word, word_ready SHALL be 1 if more bits remain; a word accepted then loads shreg and SHIFT continues with no gap.
REQ-023 A final partial word SHALL shift only len mod WORD_W bits; its remaining bits are discarded.
REQ-024 FINISH SHALL last one cycle: done=1, then IDLE.
REQ-025 busy SHALL be 1 in FETCH, SHIFT and FINISH.
REQ-026 start while busy SHALL be ignored.
REQ-027 Readback: each cycle cfg_shift_en=1, cfg_sin SHALL be sampled into rb_shreg at bit position rb_cnt.
REQ-028 On every WORD_W-th sample, and on the final sample of a load if partial, rb_valid SHALL pulse for one cycle the cycle after, with the word zero-padded in the upper bits.
REQ-029 rb_valid has no backpressure.
REQ-030 cfg_shift_en SHALL be a registered output, glitch-free, and updated only on the config_clk rising edge.
REQ-031 Bit and word counters SHALL be LEN_W wide and SHALL NOT wrap within a load; chain_len up to 2^LEN_W-1 is supported.

Reset
REQ-032 While config_reset=0, state SHALL be IDLE, all counters and shift registers 0, and cfg_sout, cfg_shift_en, word_ready, busy, done, rb_valid and rb_data all 0.
REQ-033 Reset asserted mid-load SHALL abort immediately with no done pulse; chain contents are then undefined and software reloads.
REQ-034 Reset release SHALL take effect on the next config_clk edge.

Structure
REQ-035 Shared package cfg_pkg SHALL hold the FSM state enum and the WORD_W and LEN_W defaults.
REQ-036 One sub-module, cfg_deser, SHALL implement the readback capture (REQ-027..REQ-029).
REQ-037 The transmit path SHALL be implemented inline in config_loader.

Verification (bench chains 3 config_cell #4 instances, 12 bits, gated by cfg_shift_en)
REQ-038 chain_len=12, one word 0x0000_0ABC always valid -> 12 consecutive cfg_shift_en cycles; cells hold 0xC, 0xB, 0xA last-to-first; done on cycle 13 after FETCH accept.
REQ-039 chain_len=40, WORD_W=32, two words, word_valid always 1 -> 40 contiguous shift cycles with no gap across the word boundary; second word bits 8..31 are unused.
REQ-040 chain_len=40, second word delayed 5 cycles -> cfg_shift_en low for exactly 5 cycles; chain contents equal those of the no-stall run.
REQ-041 chain_len=0 -> done one cycle after start; no cfg_shift_en and no word_ready.
REQ-042 Load 0xFFF, then reload 0x000 with chain_len=12 -> rb_valid pulses once with rb_data=0x0000_0FFF.
REQ-043 Reset driven low after 6 shift bits -> all outputs 0 within the same cycle, no done; a following start runs normally.
